mem_port_arbiter: RTL and testbench

- Shares one single-ported unified instruction/data memory between IF-stage fetch and MEM-stage load/store of the pipelined MIPS core.
- Grants one requester at a time, registers the memory command, and holds it until the memory acknowledges.
- Returns read data to the granted requester with a one-cycle ready pulse.
- The hazard logic uses missing ready pulses to stall the pipeline.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/arb_streak_cnt.sv | 54 +++++
 rtl/mem_port_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the unified memory port arbiter.
//   arb_state_t : arbiter FSM state encoding
//   DEF_ADDR_W  : default address width of all ports
//   DEF_DATA_W  : default data width of all ports
//   BE_ALL      : byte-enable pattern for full-word instruction fetches
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    localparam logic [3:0] BE_ALL = 4'hF;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_DATA  = 2'd1,
        ARB_FETCH = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_streak_cnt.sv
// arb_streak_cnt: saturating count of data grants made while a fetch waits.
// Ports:
//   clk, rst : core clock, synchronous active-high reset
//   inc      : a data grant was made while if_req was high
//   clr      : a fetch grant was made
//   sat      : registered flag, count has reached MAX_DATA_STREAK
module arb_streak_cnt
    import mem_arb_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int                 CNT_W   = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(MAX_DATA_STREAK);
    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             sat_r;
    logic             sat_s;

    // Next count: clear wins over increment; increment stops at the limit.
    always_comb begin
        cnt_s = cnt_r;
        if (clr) begin
            cnt_s = {CNT_W{1'b0}};
        end else if (inc && (cnt_r != CNT_MAX)) begin
            cnt_s = cnt_r + CNT_ONE;
        end else begin
            cnt_s = cnt_r;
        end
        sat_s = (cnt_s == CNT_MAX);
    end

    // Count and saturation flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
            sat_r <= 1'b0;
        end else begin
            cnt_r <= cnt_s;
            sat_r <= sat_s;
        end
    end

    assign sat = sat_r;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported unified memory between the
// IF-stage fetch port (if_*) and the MEM-stage load/store port (dm_*).
// One requester is granted at a time from ARB_IDLE; the memory command
// (mem_*) is registered and held until mem_ack, after which the matching
// ready pulses for one cycle and read data is captured into if_rdata or
// dm_rdata. Data has priority over fetch because MEM holds the older
// instruction.
// Ports:
//   clk, rst               : core clock, synchronous active-high reset
//   if_req/if_addr         : fetch request and PC, held until if_ready
//   if_rdata/if_ready      : fetched instruction and one-cycle done pulse
//   dm_req/we/be/addr/wdata: load/store request, held until dm_ready
//   dm_rdata/dm_ready      : load data and one-cycle done pulse
//   mem_req/we/be/addr/wdata: registered memory command
//   mem_rdata/mem_ack      : memory read data and completion pulse
//   busy                   : high while a command is outstanding
// Build option: define ARB_FAIRNESS_EN to let a waiting fetch win after
// MAX_DATA_STREAK consecutive data grants (arb_streak_cnt).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W          = DEF_ADDR_W,
    parameter int DATA_W          = DEF_DATA_W,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [3:0]        dm_be,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              busy
);

    if (MAX_DATA_STREAK < 1) begin : g_bad_streak
        $error("mem_port_arbiter: MAX_DATA_STREAK must be at least 1");
    end

    arb_state_t        state_r,     state_s;
    logic              mem_req_r,   mem_req_s;
    logic              mem_we_r,    mem_we_s;
    logic [3:0]        mem_be_r,    mem_be_s;
    logic [ADDR_W-1:0] mem_addr_r,  mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_r, mem_wdata_s;
    logic [DATA_W-1:0] if_rdata_r,  if_rdata_s;
    logic              if_ready_r,  if_ready_s;
    logic [DATA_W-1:0] dm_rdata_r,  dm_rdata_s;
    logic              dm_ready_r,  dm_ready_s;
    logic              busy_r,      busy_s;

    logic              grant_data_s;
    logic              fair_inc_s;
    logic              fair_clr_s;
    logic              fair_sat_s;

`ifdef ARB_FAIRNESS_EN
    arb_streak_cnt #(
        .MAX_DATA_STREAK (MAX_DATA_STREAK)
    ) u_streak (
        .clk (clk),
        .rst (rst),
        .inc (fair_inc_s),
        .clr (fair_clr_s),
        .sat (fair_sat_s)
    );
`else
    // Strict data priority: the streak limit is never reached.
    assign fair_sat_s = 1'b0;
`endif

    // Data is granted unless a starved fetch is also waiting.
    assign grant_data_s = dm_req && !(if_req && fair_sat_s);

    // Next-state and next-output logic of the arbiter FSM.
    always_comb begin
        state_s     = state_r;
        mem_req_s   = mem_req_r;
        mem_we_s    = mem_we_r;
        mem_be_s    = mem_be_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        if_rdata_s  = if_rdata_r;
        dm_rdata_s  = dm_rdata_r;
        if_ready_s  = 1'b0;
        dm_ready_s  = 1'b0;
        fair_inc_s  = 1'b0;
        fair_clr_s  = 1'b0;

        case (state_r)
            ARB_IDLE: begin
                // mem_ack arriving here is stray and deliberately ignored.
                if (grant_data_s) begin
                    state_s     = ARB_DATA;
                    mem_req_s   = 1'b1;
                    mem_we_s    = dm_we;
                    mem_be_s    = dm_be;
                    mem_addr_s  = dm_addr;
                    mem_wdata_s = dm_wdata;
                    fair_inc_s  = if_req;
                end else if (if_req) begin
                    state_s     = ARB_FETCH;
                    mem_req_s   = 1'b1;
                    mem_we_s    = 1'b0;
                    mem_be_s    = BE_ALL;
                    mem_addr_s  = if_addr;
                    fair_clr_s  = 1'b1;
                end else begin
                    state_s     = ARB_IDLE;
                end
            end
            ARB_DATA: begin
                if (mem_ack) begin
                    state_s    = ARB_IDLE;
                    mem_req_s  = 1'b0;
                    dm_ready_s = 1'b1;
                    if (!mem_we_r) begin
                        dm_rdata_s = mem_rdata;
                    end else begin
                        dm_rdata_s = dm_rdata_r;
                    end
                end else begin
                    state_s = ARB_DATA;
                end
            end
            ARB_FETCH: begin
                if (mem_ack) begin
                    state_s    = ARB_IDLE;
                    mem_req_s  = 1'b0;
                    if_ready_s = 1'b1;
                    if_rdata_s = mem_rdata;
                end else begin
                    state_s = ARB_FETCH;
                end
            end
            default: begin
                state_s   = ARB_IDLE;
                mem_req_s = 1'b0;
            end
        endcase

        busy_s = (state_s != ARB_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ARB_IDLE;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_be_r    <= 4'h0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            if_rdata_r  <= {DATA_W{1'b0}};
            if_ready_r  <= 1'b0;
            dm_rdata_r  <= {DATA_W{1'b0}};
            dm_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            mem_req_r   <= mem_req_s;
            mem_we_r    <= mem_we_s;
            mem_be_r    <= mem_be_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            if_rdata_r  <= if_rdata_s;
            if_ready_r  <= if_ready_s;
            dm_rdata_r  <= dm_rdata_s;
            dm_ready_r  <= dm_ready_s;
            busy_r      <= busy_s;
        end
    end

    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_be    = mem_be_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign if_rdata  = if_rdata_r;
    assign if_ready  = if_ready_r;
    assign dm_rdata  = dm_rdata_r;
    assign dm_ready  = dm_ready_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: self-checking bench for mem_port_arbiter.
// A behavioural memory answers each command after ack_delay cycles; expected
// ready events are queued when requests are driven and checked on each pulse.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [3:0]  dm_be = 4'h0;
    logic [31:0] dm_addr = 32'h0;
    logic [31:0] dm_wdata = 32'h0;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack;
    logic        busy;

    logic        model_ack = 1'b0;
    logic        stray_ack = 1'b0;
    logic        mem_auto  = 1'b1;
    int          ack_delay = 0;

    assign mem_ack = mem_auto ? model_ack : stray_ack;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory contents as seen by the bench.
    function automatic logic [31:0] mem_rd_data(input logic [31:0] a);
        case (a)
            32'h0000_3000: return 32'h2008_0005;
            32'h0000_0020: return 32'h1234_5678;
            default:       return a ^ 32'h5A5A_0000;
        endcase
    endfunction

    // Scoreboard of expected ready pulses, in completion order.
    typedef struct {
        bit          is_data;
        logic [31:0] rdata;
        int          cycle;   // -1: do not check timing
    } exp_t;
    exp_t        sb_q[$];
    logic [31:0] grant_q[$];

    // Behavioural memory: records grants, checks command stability, acks.
    logic        in_cmd = 1'b0;
    int          wait_cnt = 0;
    logic        snap_we;
    logic [3:0]  snap_be;
    logic [31:0] snap_addr;
    logic [31:0] snap_wdata;
    always @(negedge clk) begin
        if (model_ack) begin
            check("mem_req_drop_after_ack", {63'd0, mem_req}, 64'd0);
            model_ack = 1'b0;
            in_cmd    = 1'b0;
        end else if (mem_auto && mem_req) begin
            if (!in_cmd) begin
                in_cmd     = 1'b1;
                wait_cnt   = 0;
                snap_we    = mem_we;
                snap_be    = mem_be;
                snap_addr  = mem_addr;
                snap_wdata = mem_wdata;
                grant_q.push_back(mem_addr);
            end else begin
                wait_cnt++;
                check("mem_stable", {mem_we, mem_be, mem_addr, mem_wdata[26:0]},
                      {snap_we, snap_be, snap_addr, snap_wdata[26:0]});
            end
            if (wait_cnt == ack_delay) begin
                model_ack = 1'b1;
                mem_rdata = mem_rd_data(mem_addr);
            end
        end else begin
            in_cmd = 1'b0;
        end
    end

    // Scoreboard monitor: every ready pulse must match the queue head.
    always @(negedge clk) begin : sb_mon
        exp_t e;
        if (if_ready || dm_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_ready", {62'd0, if_ready, dm_ready}, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("ready_port", {62'd0, if_ready, dm_ready}, e.is_data ? 64'd1 : 64'd2);
                check("ready_rdata", e.is_data ? dm_rdata : if_rdata, e.rdata);
                check("busy_at_ready", {63'd0, busy}, 64'd0);
                if (e.cycle >= 0) check("ready_cycle", cyc, e.cycle);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          is_data;
        bit          we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          k;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;
    vec_t vecs[6];

    logic [31:0] exp_grants[6];
    int          fetch_pos;
    int          di;
    bit          got;
    bit          dm_done;
    bit          if_done;

    initial begin
        vecs[0] = '{1'b0, 1'b0, 4'hF, 32'h0000_3000, 32'h0, 0, 32'h2008_0005, 2};
        vecs[1] = '{1'b1, 1'b0, 4'hF, 32'h0000_0020, 32'h0, 3, 32'h1234_5678, 5};
        vecs[2] = '{1'b1, 1'b1, 4'hF, 32'h0000_0010, 32'hCAFE_F00D, 1, 32'h1234_5678, 3};
        vecs[3] = '{1'b1, 1'b1, 4'h3, 32'h0000_0044, 32'h0BAD_BEEF, 0, 32'h1234_5678, 2};
        vecs[4] = '{1'b0, 1'b0, 4'hF, 32'h0000_3004, 32'h0, 2, 32'h5A5A_3004, 4};
        vecs[5] = '{1'b1, 1'b0, 4'hF, 32'h0000_0080, 32'h0, 0, 32'h5A5A_0080, 2};

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_mem_cmd", {mem_req, mem_we, mem_be, mem_addr}, 64'd0);
        check("rst_mem_wdata", mem_wdata, 64'd0);
        check("rst_ready_busy", {61'd0, if_ready, dm_ready, busy}, 64'd0);
        check("rst_rdata", {if_rdata, dm_rdata}, 64'd0);
        rst = 1'b0;

        // Table-driven single transactions.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ack_delay = vecs[i].k;
            if (vecs[i].is_data) begin
                dm_req = 1'b1; dm_we = vecs[i].we; dm_be = vecs[i].be;
                dm_addr = vecs[i].addr; dm_wdata = vecs[i].wdata;
            end else begin
                if_req = 1'b1; if_addr = vecs[i].addr;
            end
            sb_q.push_back('{is_data: vecs[i].is_data, rdata: vecs[i].exp_rdata,
                             cycle: cyc + vecs[i].exp_lat});
            @(negedge clk);
            check("grant_req_busy", {62'd0, mem_req, busy}, 64'd3);
            check("grant_we", {63'd0, mem_we}, {63'd0, vecs[i].is_data & vecs[i].we});
            check("grant_be", {60'd0, mem_be}, vecs[i].is_data ? {60'd0, vecs[i].be} : {60'd0, BE_ALL});
            check("grant_addr", mem_addr, vecs[i].addr);
            if (vecs[i].is_data) check("grant_wdata", mem_wdata, vecs[i].wdata);
            got = 1'b0;
            for (int w = 0; w < 20; w++) begin
                @(negedge clk);
                if (vecs[i].is_data ? dm_ready : if_ready) begin
                    got = 1'b1;
                    break;
                end
            end
            check("solo_ready_seen", {63'd0, got}, 64'd1);
            dm_req = 1'b0;
            if_req = 1'b0;
        end

        // Simultaneous store and fetch: data first, then fetch after IDLE.
        @(negedge clk);
        ack_delay = 0;
        grant_q.delete();
        dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'hF; dm_addr = 32'h10; dm_wdata = 32'hCAFE_F00D;
        if_req = 1'b1; if_addr = 32'h3008;
        sb_q.push_back('{is_data: 1'b1, rdata: 32'h5A5A_0080, cycle: -1});
        sb_q.push_back('{is_data: 1'b0, rdata: 32'h5A5A_3008, cycle: -1});
        @(negedge clk);
        check("both_first_we_addr", {31'd0, mem_we, mem_addr}, {31'd0, 1'b1, 32'h10});
        dm_done = 1'b0; if_done = 1'b0;
        for (int w = 0; w < 40; w++) begin
            if (dm_ready) begin dm_req = 1'b0; dm_done = 1'b1; end
            if (if_ready) begin if_req = 1'b0; if_done = 1'b1; end
            if (dm_done && if_done) break;
            @(negedge clk);
        end
        check("both_done", {62'd0, dm_done, if_done}, 64'd3);
        check("both_grant_cnt", grant_q.size(), 64'd2);
        if (grant_q.size() == 2) begin
            check("both_grant_order", {grant_q[0], grant_q[1]}, {32'h10, 32'h3008});
        end

        // Fetch held while five loads issue back to back.
`ifdef ARB_FAIRNESS_EN
        fetch_pos = 4;
`else
        fetch_pos = 5;
`endif
        di = 0;
        for (int g = 0; g < 6; g++) begin
            if (g == fetch_pos) begin
                exp_grants[g] = 32'h300C;
                sb_q.push_back('{is_data: 1'b0, rdata: mem_rd_data(32'h300C), cycle: -1});
            end else begin
                exp_grants[g] = 32'h100 + 32'(di) * 32'd4;
                sb_q.push_back('{is_data: 1'b1, rdata: mem_rd_data(exp_grants[g]), cycle: -1});
                di++;
            end
        end
        @(negedge clk);
        grant_q.delete();
        di = 0;
        if_req = 1'b1; if_addr = 32'h300C;
        dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h100;
        dm_done = 1'b0; if_done = 1'b0;
        for (int w = 0; w < 80; w++) begin
            @(negedge clk);
            if (dm_ready) begin
                di++;
                if (di < 5) dm_addr = 32'h100 + 32'(di) * 32'd4;
                else begin dm_req = 1'b0; dm_done = 1'b1; end
            end
            if (if_ready) begin if_req = 1'b0; if_done = 1'b1; end
            if (dm_done && if_done) break;
        end
        check("streak_done", {62'd0, dm_done, if_done}, 64'd3);
        check("streak_grant_cnt", grant_q.size(), 64'd6);
        for (int g = 0; g < 6; g++) begin
            if (g < grant_q.size()) check($sformatf("streak_grant_%0d", g), grant_q[g], exp_grants[g]);
        end

        // Reset during a data access, then a stray ack in ARB_IDLE.
        @(negedge clk);
        ack_delay = 10;
        dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h40;
        @(negedge clk);
        check("rst_mid_granted", {62'd0, mem_req, busy}, 64'd3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        dm_req = 1'b0;
        mem_auto = 1'b0;
        check("rst_mid_dropped", {61'd0, mem_req, busy, dm_ready}, 64'd0);
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        check("stray_ack_ignored", {61'd0, mem_req, busy, dm_ready}, 64'd0);
        check("stray_ack_rdata", {if_rdata, dm_rdata}, 64'd0);
        repeat (2) @(negedge clk);
        check("stray_ack_idle", {61'd0, mem_req, busy, if_ready}, 64'd0);
        mem_auto = 1'b1;

        @(negedge clk);
        check("sb_empty", sb_q.size(), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
